// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: ALU control codes and divider FSM states.
package mips_defs;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_DIV  = 5'b10110;
    localparam logic [4:0] ALU_DIVU = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in the execute stage.
// Stalls the front of the pipe for WIDTH+1 cycles; quotient on loE, remainder on hiE.
module div_unit
    import mips_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       alucontrolE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancelE,
    output logic             stall_divE,
    output logic             doneE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t state, stateNext;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] dvdReg;
    logic [WIDTH-1:0] dvsReg;
    logic             qNeg;
    logic             rNeg;
    logic             dvsZero;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;
    logic [WIDTH-1:0] heldHi;
    logic [WIDTH-1:0] heldLo;

    logic             isDivOp;
    logic             isSigned;
    logic             start;
    logic             lastStep;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;

    assign isDivOp  = (alucontrolE == ALU_DIV) || (alucontrolE == ALU_DIVU);
    assign isSigned = (alucontrolE == ALU_DIV);
    assign start    = isDivOp & ~cancelE & ~rst & (state == IDLE);
    assign lastStep = (cnt == CW'(WIDTH - 1));

    // Operand magnitudes; DIVU passes raw values through
    always_comb begin
        absA = srcaE;
        absB = srcbE;
        if (isSigned && srcaE[WIDTH-1]) absA = WIDTH'(-srcaE);
        if (isSigned && srcbE[WIDTH-1]) absB = WIDTH'(-srcbE);
    end

    // One restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        shifted = {remReg, dvdReg[WIDTH-1]};
        trial   = shifted - {1'b0, dvsReg};
        remNext = shifted[WIDTH-1:0];
        quoNext = {dvdReg[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            remNext = trial[WIDTH-1:0];
            quoNext = {dvdReg[WIDTH-2:0], 1'b1};
        end
        quoFix = quoNext;
        remFix = remNext;
        if (!dvsZero) begin
            if (qNeg) quoFix = WIDTH'(-quoNext);
            if (rNeg) remFix = WIDTH'(-remNext);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = BUSY;
            BUSY: begin
                if (cancelE)       stateNext = IDLE;
                else if (lastStep) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs; the committed result only moves once a DONE cycle survives without cancel
    always_comb begin
        stall_divE = 1'b0;
        doneE      = 1'b0;
        hiE        = heldHi;
        loE        = heldLo;
        case (state)
            IDLE: stall_divE = start;
            BUSY: stall_divE = ~cancelE;
            DONE: begin
                doneE = ~cancelE;
                if (!cancelE) begin
                    hiE = fixHi;
                    loE = fixLo;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            remReg  <= '0;
            dvdReg  <= '0;
            dvsReg  <= '0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            dvsZero <= 1'b0;
            fixHi   <= '0;
            fixLo   <= '0;
            heldHi  <= '0;
            heldLo  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvdReg  <= absA;
                    dvsReg  <= absB;
                    qNeg    <= isSigned & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                    rNeg    <= isSigned & srcaE[WIDTH-1];
                    dvsZero <= (srcbE == '0);
                    remReg  <= '0;
                    cnt     <= '0;
                end
                BUSY: begin
                    remReg <= remNext;
                    dvdReg <= quoNext;
                    cnt    <= cnt + CW'(1);
                    if (lastStep) begin
                        fixLo <= quoFix;
                        fixHi <= remFix;
                    end
                end
                DONE: if (!cancelE) begin
                    heldHi <= fixHi;
                    heldLo <= fixLo;
                end
                default: ;
            endcase
        end
    end

endmodule
